// File: rtl/io_handshake_responder_pkg.sv
// Shared types and constants for the CPU IN/OUT responder
// and its BCD display helpers.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_WAIT,
    OUT_HOLD
  } state_e;

  localparam logic [3:0] ENTER_CODE = 4'hF;
  localparam logic [9:0] BCD_MAX    = 10'd999;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

endpackage

// File: rtl/io_handshake_responder_if.sv
// CPU-side IN/OUT handshake bundle: request pulses in,
// stall and completion pulses back.
interface io_handshake_responder_if #(
  parameter int DATA_W = 32
) ();

  logic              req_in;
  logic              req_out;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              out_ack;

  modport master (
    output req_in,
    output req_out,
    output out_data,
    input  busy,
    input  rd_data,
    input  rd_valid,
    input  out_ack
  );

  modport slave (
    input  req_in,
    input  req_out,
    input  out_data,
    output busy,
    output rd_data,
    output rd_valid,
    output out_ack
  );

endinterface

// File: rtl/io_handshake_responder_bin_to_bcd.sv
// Combinational double-dabble: 10-bit binary to three BCD
// digits. Inputs above 999 are the caller's problem.
module bin_to_bcd (
  input  logic [9:0] bin,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds
);

  logic [21:0] sh;

  always_comb begin
    sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
      if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
      sh = {sh[20:0], 1'b0};
    end
  end

  assign units    = sh[13:10];
  assign tens     = sh[17:14];
  assign hundreds = sh[21:18];

endmodule

// File: rtl/io_handshake_responder.sv
// Device-side responder for CPU IN/OUT: stalls the CPU while
// the user keys in a number or acknowledges a displayed word.
module io_handshake_responder
  import io_pkg::*;
#(
  parameter int         MAX_DIGITS = 3,
  parameter int         DATA_W     = 32,
  parameter logic [3:0] ENTER_CODE = io_pkg::ENTER_CODE
) (
  input  logic                     clk,
  input  logic                     reset,
  io_handshake_responder_if.slave  cpu,
  input  logic [3:0]               sw,
  input  logic                     btn,
  output logic                     entry_err,
  output logic                     overflow,
  output logic [3:0]               bcd_units,
  output logic [3:0]               bcd_tens,
  output logic [3:0]               bcd_hundreds
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_e            state_q, state_d;
  logic [9:0]        acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              btn_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              out_ack_q, out_ack_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        units_q, tens_q, hund_q;
  logic [3:0]        units_c, tens_c, hund_c;
  logic              disp_upd;
  logic [9:0]        disp_bin;

  logic              press;
  logic              is_digit;
  logic              ovf_in;
  logic [9:0]        sat_val;
  logic [9:0]        acc_next;

  assign press    = btn & ~btn_q;
  assign is_digit = sw <= DIGIT_MAX;
  assign ovf_in   = cpu.out_data > DATA_W'(BCD_MAX);
  assign sat_val  = ovf_in ? BCD_MAX : cpu.out_data[9:0];
  // acc is at most 99 whenever a digit is accepted, so this stays <= 999
  assign acc_next = acc_q * 10'd10 + {6'd0, sw};

  bin_to_bcd u_bcd (
    .bin      (disp_bin),
    .units    (units_c),
    .tens     (tens_c),
    .hundreds (hund_c)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    out_ack_d  = 1'b0;
    err_d      = 1'b0;
    ovf_d      = ovf_q;
    disp_upd   = 1'b0;
    disp_bin   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (cpu.req_in) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IN_WAIT;
        end else if (cpu.req_out) begin
          ovf_d    = ovf_in;
          disp_bin = sat_val;
          disp_upd = 1'b1;
          state_d  = OUT_HOLD;
        end
      end
      IN_WAIT: begin
        if (press) begin
          unique case (1'b1)
            is_digit && (cnt_q < CNT_W'(MAX_DIGITS)): begin
              acc_d    = acc_next;
              cnt_d    = cnt_q + 1'b1;
              disp_bin = acc_next;
              disp_upd = 1'b1;
            end
            sw == ENTER_CODE: begin
              rd_data_d  = DATA_W'(acc_q);
              rd_valid_d = 1'b1;
              state_d    = IDLE;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      OUT_HOLD: begin
        if (press) begin
          out_ack_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      btn_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      out_ack_q  <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      units_q    <= '0;
      tens_q     <= '0;
      hund_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      out_ack_q  <= out_ack_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      if (disp_upd) begin
        units_q <= units_c;
        tens_q  <= tens_c;
        hund_q  <= hund_c;
      end
    end
  end

  assign cpu.busy     = (state_q != IDLE) |
                        ((state_q == IDLE) & (cpu.req_in | cpu.req_out));
  assign cpu.rd_data  = rd_data_q;
  assign cpu.rd_valid = rd_valid_q;
  assign cpu.out_ack  = out_ack_q;
  assign entry_err    = err_q;
  assign overflow     = ovf_q;
  assign bcd_units    = units_q;
  assign bcd_tens     = tens_q;
  assign bcd_hundreds = hund_q;

endmodule

// File: tb/tb_io_handshake_responder.sv
// Directed bench for the IN/OUT responder: keyed entry,
// display/ack, priority and mid-transaction reset.
module tb_io_handshake_responder;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic       btn;
  logic       entry_err;
  logic       overflow;
  logic [3:0] bcd_units, bcd_tens, bcd_hundreds;

  int checks = 0;
  int errors = 0;

  io_handshake_responder_if #(.DATA_W(32)) cpu_if ();

  io_handshake_responder dut (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cpu_if.slave),
    .sw           (sw),
    .btn          (btn),
    .entry_err    (entry_err),
    .overflow     (overflow),
    .bcd_units    (bcd_units),
    .bcd_tens     (bcd_tens),
    .bcd_hundreds (bcd_hundreds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] h,
                          input logic [3:0] t, input logic [3:0] u);
    chk({tag, "_h"}, 32'(bcd_hundreds), 32'(h));
    chk({tag, "_t"}, 32'(bcd_tens), 32'(t));
    chk({tag, "_u"}, 32'(bcd_units), 32'(u));
  endtask

  // Rising edge lands on the next clock; results checked right after
  task automatic press_on(input logic [3:0] v);
    sw  = v;
    btn = 1'b1;
    tick();
  endtask

  task automatic release_btn();
    btn = 1'b0;
    tick();
  endtask

  task automatic press(input logic [3:0] v);
    press_on(v);
    release_btn();
  endtask

  task automatic pulse_req(input logic i, input logic o,
                           input logic [31:0] d);
    cpu_if.req_in   = i;
    cpu_if.req_out  = o;
    cpu_if.out_data = d;
    #1;
    chk("busy_req_cycle", 32'(cpu_if.busy), 32'd1);
    tick();
    cpu_if.req_in  = 1'b0;
    cpu_if.req_out = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw = 4'd0;
    btn = 1'b0;
    cpu_if.req_in = 1'b0;
    cpu_if.req_out = 1'b0;
    cpu_if.out_data = '0;
    #12;
    chk("rst_busy", 32'(cpu_if.busy), 32'd0);
    chk("rst_rd_data", cpu_if.rd_data, 32'd0);
    chk("rst_rd_valid", 32'(cpu_if.rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk_disp("rst_disp", 4'd0, 4'd0, 4'd0);
    reset = 1'b0;
    tick();

    // Entry 1-2-3 then enter
    pulse_req(1'b1, 1'b0, 32'd0);
    chk("in_busy", 32'(cpu_if.busy), 32'd1);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    chk_disp("in123", 4'd1, 4'd2, 4'd3);
    chk("in123_pre_valid", 32'(cpu_if.rd_valid), 32'd0);
    press_on(4'hF);
    chk("in123_valid", 32'(cpu_if.rd_valid), 32'd1);
    chk("in123_data", cpu_if.rd_data, 32'd123);
    chk("in123_busy", 32'(cpu_if.busy), 32'd0);
    release_btn();
    chk("in123_valid_pulse", 32'(cpu_if.rd_valid), 32'd0);

    // Button held across the request must not count
    sw  = 4'd7;
    btn = 1'b1;
    tick();
    pulse_req(1'b1, 1'b0, 32'd0);
    tick();
    chk_disp("held", 4'd1, 4'd2, 4'd3);
    release_btn();
    press(4'd7);
    press_on(4'hF);
    chk("held_data", cpu_if.rd_data, 32'd7);
    chk("held_valid", 32'(cpu_if.rd_valid), 32'd1);
    release_btn();
    chk_disp("held_disp", 4'd0, 4'd0, 4'd7);

    // Fourth digit and a non-digit code are rejected
    pulse_req(1'b1, 1'b0, 32'd0);
    press(4'd4);
    press(4'd4);
    press(4'd4);
    press_on(4'd4);
    chk("d4_err", 32'(entry_err), 32'd1);
    release_btn();
    chk("d4_err_pulse", 32'(entry_err), 32'd0);
    press_on(4'hB);
    chk("keyB_err", 32'(entry_err), 32'd1);
    release_btn();
    chk_disp("keyB_disp", 4'd4, 4'd4, 4'd4);
    press_on(4'hF);
    chk("d444_data", cpu_if.rd_data, 32'd444);
    chk("d444_err", 32'(entry_err), 32'd0);
    release_btn();

    // OUT of a small value
    pulse_req(1'b0, 1'b1, 32'd42);
    chk("out42_busy", 32'(cpu_if.busy), 32'd1);
    chk_disp("out42", 4'd0, 4'd4, 4'd2);
    chk("out42_ovf", 32'(overflow), 32'd0);
    tick();
    chk("out42_hold", 32'(cpu_if.busy), 32'd1);
    chk("out42_noack", 32'(cpu_if.out_ack), 32'd0);
    press_on(4'd0);
    chk("out42_ack", 32'(cpu_if.out_ack), 32'd1);
    chk("out42_idle", 32'(cpu_if.busy), 32'd0);
    release_btn();
    chk("out42_ack_pulse", 32'(cpu_if.out_ack), 32'd0);
    chk_disp("out42_keep", 4'd0, 4'd4, 4'd2);

    // OUT of an oversize value saturates
    pulse_req(1'b0, 1'b1, 32'd5000);
    chk_disp("out5000", 4'd9, 4'd9, 4'd9);
    chk("out5000_ovf", 32'(overflow), 32'd1);
    press_on(4'd0);
    chk("out5000_ack", 32'(cpu_if.out_ack), 32'd1);
    release_btn();
    chk("out5000_ovf_keep", 32'(overflow), 32'd1);

    // Simultaneous requests: IN wins, OUT dropped
    pulse_req(1'b1, 1'b1, 32'd7);
    chk("both_busy", 32'(cpu_if.busy), 32'd1);
    chk_disp("both_disp", 4'd9, 4'd9, 4'd9);
    press_on(4'd0);
    chk("both_noack", 32'(cpu_if.out_ack), 32'd0);
    chk("both_still_busy", 32'(cpu_if.busy), 32'd1);
    release_btn();
    press_on(4'hF);
    chk("both_valid", 32'(cpu_if.rd_valid), 32'd1);
    chk("both_data", cpu_if.rd_data, 32'd0);
    release_btn();

    // Reset mid-entry discards it
    pulse_req(1'b1, 1'b0, 32'd0);
    press(4'd5);
    chk_disp("pre_rst", 4'd0, 4'd0, 4'd5);
    reset = 1'b1;
    #2;
    chk("mid_rst_busy", 32'(cpu_if.busy), 32'd0);
    chk("mid_rst_valid", 32'(cpu_if.rd_valid), 32'd0);
    chk_disp("mid_rst_disp", 4'd0, 4'd0, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", 32'(cpu_if.rd_valid), 32'd0);
    pulse_req(1'b1, 1'b0, 32'd0);
    press_on(4'hF);
    chk("post_rst_valid2", 32'(cpu_if.rd_valid), 32'd1);
    chk("post_rst_data", cpu_if.rd_data, 32'd0);
    release_btn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
